muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers.
//  Sits in EX beside the main ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//  Raises busy so the hazard unit stalls MFHI/MFLO and any new mul/div until the result is final.
//  Replaces the single-cycle HiReg/LoReg path; a flush from the branch logic can abort it.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits (must be even, >= 4)
// PORTS
//  clk       in   1      rising-edge clock
//  Reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request new op; sampled only in IDLE
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a         in   WIDTH  rs operand (multiplicand / dividend)
//  b         in   WIDTH  rt operand (multiplier / divisor)
//  flush     in   1      abort in-flight op; HI/LO unchanged
//  hi_we     in   1      MTHI: write wdata into HI
//  lo_we     in   1      MTLO: write wdata into LO
//  wdata     in   WIDTH  MTHI/MTLO data
//  busy      out  1      op in flight (RUN or FIX); drives the stall request
//  done      out  1      one-cycle pulse on the cycle HI/LO take a new result
//  div_zero  out  1      sticky flag; set by a DIV/DIVU with b==0, cleared at the next start
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async): state=IDLE; hi=lo=0; busy=done=div_zero=0; iteration counter=0.
//  FSM: IDLE -> RUN on accepted start. RUN -> FIX after WIDTH iterations. FIX -> IDLE.
//    Any state -> IDLE on flush, with no HI/LO update.
//  IDLE: start=1 latches |a|,|b| (signed ops) or a,b (unsigned ops), latches result signs,
//    clears div_zero, and sets busy at the next edge.
//  RUN: radix-2, one bit per cycle, counter runs 0..WIDTH-1.
//    Multiply: shift-add into a 2*WIDTH accumulator.
//    Divide: restoring shift-subtract. Quotient goes to the low half, remainder to the high half.
//  FIX: apply sign correction, write HI/LO, pulse done, drop busy. All three take effect
//    on the same edge.
//  Latency: start accepted at edge N -> hi/lo valid and done=1 after edge N+WIDTH+1.
//    busy is high for WIDTH+1 cycles. There is no early termination.
//  Signed MULT: {hi,lo} = 2*WIDTH-bit two's-complement product.
//  Signed DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
//  Divide by zero, b==0 (signed or unsigned): lo = {WIDTH{1'b1}}, hi = a, div_zero=1.
//    Full latency still applies.
//  Overflow, DIV most-negative / -1: lo = most-negative value, hi = 0. No flag.
//  start while busy: ignored, with no effect. The hazard unit must not issue one.
//  hi_we/lo_we: write on the next edge in any state.
//    If busy, the write aborts the in-flight op exactly like flush.
//    hi_we+lo_we together write both registers.
//  Same-cycle priority: Reset > flush > hi_we/lo_we > FIX result write > start.
//    A start is ignored in any cycle where flush, hi_we or lo_we is high.
//  Operands are captured at start. Later changes on a/b do not affect the op in flight.
// TESTING (WIDTH=32)
//  1. MULT a=FFFFFFFD b=00000007 -> done at edge N+33; hi=FFFFFFFF lo=FFFFFFEB; busy high 33 cycles.
//  2. MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//     DIVU a=00000007 b=00000000 -> lo=FFFFFFFF hi=00000007, div_zero=1.
//  3. DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF.
//     DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000, div_zero=0.
//  4. Preload hi=11111111 lo=22222222. Start MULTU 5*5; flush 10 cycles in ->
//     busy=0 next edge, no done, hi/lo still 11111111/22222222.
//     A second start while busy is ignored.
//  5. MTLO wdata=CAFEF00D with start in the same cycle -> lo=CAFEF00D, busy stays 0.
//     MTHI during RUN -> op aborted, hi=wdata, no done.
//  6. Assert Reset mid-RUN between clock edges -> hi/lo/busy/done/div_zero go to 0 without a clock edge.
//     After release, a new MULT completes with the correct result.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
// Holds the op request, MTHI/MTLO writes, the HI/LO result and the unit's status.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   // Handshake: start is a one-cycle request, taken only while busy is low and no
   // flush/hi_we/lo_we is present in the same cycle; busy is the inverse of ready,
   // and done pulses once when HI/LO take the new result.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [1:0]       state_dbg;

   modport master (
      output start, op, a, b, flush, hi_we, lo_we, wdata,
      input  busy, done, div_zero, hi, lo, state_dbg
   );

   modport slave (
      input  start, op, a, b, flush, hi_we, lo_we, wdata,
      output busy, done, div_zero, hi, lo, state_dbg
   );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; works on magnitudes
// and applies the sign correction in a final FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     Reset,
   muldiv_if.slave  io
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   always_comb begin
      signed_op = ~io.op[0];
      a_neg     = signed_op & io.a[WIDTH-1];
      b_neg     = signed_op & io.b[WIDTH-1];
      a_mag     = a_neg ? -io.a : io.a;
      b_mag     = b_neg ? -io.b : io.b;

      // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      // Divide: the shifted partial remainder needs WIDTH+1 bits; bit WIDTH of the trial is the borrow.
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
      div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod_fix  = neg_lo_q ? -acc_q : acc_q;
      quot_fix  = dz_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem_fix   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      case (state_q)
         S_IDLE: begin
            if (io.start) begin
               state_d    = S_RUN;
               cnt_d      = '0;
               is_div_d   = io.op[1];
               neg_lo_d   = a_neg ^ b_neg;
               neg_hi_d   = a_neg;
               dz_d       = io.op[1] & (io.b == '0);
               div_zero_d = 1'b0;
               acc_d      = {{WIDTH{1'b0}}, (io.op[1] ? a_mag : b_mag)};
               opb_d      = io.op[1] ? b_mag : a_mag;
            end
         end
         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end
         end
         S_FIX: begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            div_zero_d = is_div_q & dz_q;
            hi_d       = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
            lo_d       = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
         end
         default: state_d = S_IDLE;
      endcase

      // MTHI/MTLO win over a result write or a start and abort anything in flight.
      if (io.hi_we || io.lo_we) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         done_d     = 1'b0;
         div_zero_d = div_zero_q;
         hi_d       = io.hi_we ? io.wdata : hi_q;
         lo_d       = io.lo_we ? io.wdata : lo_q;
      end

      if (io.flush) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         done_d     = 1'b0;
         div_zero_d = div_zero_q;
         hi_d       = hi_q;
         lo_d       = lo_q;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign io.busy      = (state_q != S_IDLE);
   assign io.done      = done_q;
   assign io.div_zero  = div_zero_q;
   assign io.hi        = hi_q;
   assign io.lo        = lo_q;
   assign io.state_dbg = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): latency, signed/unsigned results,
// divide-by-zero, overflow, flush, MTHI/MTLO aborts and asynchronous reset.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic Reset;
   int   vectors = 0;
   int   miscompares = 0;

   muldiv_if #(.WIDTH(W)) io ();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .Reset(Reset), .io(io));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      io.start = 1'b0; io.op = 2'b00; io.a = '0; io.b = '0;
      io.flush = 1'b0; io.hi_we = 1'b0; io.lo_we = 1'b0; io.wdata = '0;
   endtask

   task automatic mt(input logic whi, input logic wlo, input logic [W-1:0] data);
      @(negedge clk);
      io.hi_we = whi; io.lo_we = wlo; io.wdata = data;
      @(negedge clk);
      io.hi_we = 1'b0; io.lo_we = 1'b0;
   endtask

   // Start an op, count busy cycles, check the done pulse and result.
   // inject > 0 raises a conflicting start that many cycles into the op.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dz, input int inject);
      int cycles = 0;
      int dones  = 0;
      @(negedge clk);
      io.op = op; io.a = a; io.b = b; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0; io.a = $urandom; io.b = $urandom;
      while (io.busy === 1'b1 && cycles < 200) begin
         cycles++;
         if (io.done === 1'b1) dones++;
         io.start = (inject > 0 && cycles == inject);
         if (io.start) begin io.op = 2'b11; io.a = 32'd100; io.b = 32'd7; end
         @(negedge clk);
         io.start = 1'b0;
      end
      check({tag, "_busy_cycles"}, 64'(cycles), 64'(W + 1));
      check({tag, "_early_done"}, 64'(dones), 64'd0);
      check({tag, "_done"}, 64'(io.done), 64'd1);
      check({tag, "_hi"}, 64'(io.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(io.lo), 64'(exp_lo));
      check({tag, "_div_zero"}, 64'(io.div_zero), 64'(exp_dz));
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(io.done), 64'd0);
   endtask

   initial begin
      int dones;
      int cyc;
      idle_inputs();
      Reset = 1'b1;
      @(negedge clk);
      check("rst_hi", 64'(io.hi), 64'd0);
      check("rst_lo", 64'(io.lo), 64'd0);
      check("rst_busy", 64'(io.busy), 64'd0);
      check("rst_done", 64'(io.done), 64'd0);
      check("rst_div_zero", 64'(io.div_zero), 64'd0);
      check("rst_state", 64'(io.state_dbg), 64'd0);
      Reset = 1'b0;

      run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
      run_op("mult_minneg", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
      run_op("divu_zero", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 0);
      run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
      run_op("div_negb", 2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 0);
      run_op("div_zero_s", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0);
      run_op("divu_big", 2'b11, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0, 0);

      // Flush 10 cycles in leaves HI/LO untouched.
      mt(1'b1, 1'b0, 32'h11111111);
      mt(1'b0, 1'b1, 32'h22222222);
      check("pre_hi", 64'(io.hi), 64'h11111111);
      check("pre_lo", 64'(io.lo), 64'h22222222);
      @(negedge clk);
      io.op = 2'b01; io.a = 32'd5; io.b = 32'd5; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      for (int i = 1; i < 10; i++) @(negedge clk);
      check("flush_busy_before", 64'(io.busy), 64'd1);
      io.flush = 1'b1;
      @(negedge clk);
      io.flush = 1'b0;
      check("flush_busy", 64'(io.busy), 64'd0);
      check("flush_done", 64'(io.done), 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (io.done === 1'b1 || io.busy === 1'b1) dones++;
         @(negedge clk);
      end
      check("flush_no_done", 64'(dones), 64'd0);
      check("flush_hi", 64'(io.hi), 64'h11111111);
      check("flush_lo", 64'(io.lo), 64'h22222222);

      run_op("start_while_busy", 2'b01, 32'd5, 32'd5, 32'h00000000, 32'h00000019, 1'b0, 3);

      // MTLO together with start: write wins, op never starts.
      @(negedge clk);
      io.lo_we = 1'b1; io.wdata = 32'hCAFEF00D;
      io.start = 1'b1; io.op = 2'b00; io.a = 32'd2; io.b = 32'd3;
      @(negedge clk);
      io.lo_we = 1'b0; io.start = 1'b0;
      check("mtlo_lo", 64'(io.lo), 64'hCAFEF00D);
      check("mtlo_busy", 64'(io.busy), 64'd0);
      check("mtlo_hi", 64'(io.hi), 64'h00000000);
      @(negedge clk);
      @(negedge clk);
      check("mtlo_busy_later", 64'(io.busy), 64'd0);

      // MTHI during RUN aborts the op.
      io.op = 2'b01; io.a = 32'd5; io.b = 32'd5; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      io.hi_we = 1'b1; io.wdata = 32'hDEADBEEF;
      @(negedge clk);
      io.hi_we = 1'b0;
      check("mthi_run_busy", 64'(io.busy), 64'd0);
      check("mthi_run_hi", 64'(io.hi), 64'hDEADBEEF);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (io.done === 1'b1) dones++;
         @(negedge clk);
      end
      check("mthi_run_no_done", 64'(dones), 64'd0);
      check("mthi_run_lo", 64'(io.lo), 64'hCAFEF00D);

      // Asynchronous reset mid-RUN, between clock edges.
      io.op = 2'b00; io.a = 32'd3; io.b = 32'd4; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      #2 Reset = 1'b1;
      #1;
      check("arst_run_busy", 64'(io.busy), 64'd0);
      check("arst_run_hi", 64'(io.hi), 64'd0);
      check("arst_run_lo", 64'(io.lo), 64'd0);
      @(negedge clk);
      Reset = 1'b0;

      // Asynchronous reset while done and div_zero are high.
      io.op = 2'b11; io.a = 32'd7; io.b = 32'd0; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      cyc = 0;
      while (io.done !== 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      check("arst_pre_done", 64'(io.done), 64'd1);
      check("arst_pre_div_zero", 64'(io.div_zero), 64'd1);
      #2 Reset = 1'b1;
      #1;
      check("arst_done", 64'(io.done), 64'd0);
      check("arst_div_zero", 64'(io.div_zero), 64'd0);
      check("arst_hi", 64'(io.hi), 64'd0);
      check("arst_lo", 64'(io.lo), 64'd0);
      @(negedge clk);
      Reset = 1'b0;

      run_op("mult_after_rst", 2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
